// File: rtl/decoupler_if.sv
// Purpose: enq/full producer side and deq/empty consumer side of the decoupler as one bundle.
// Latency: none; wires only.
// Backpressure: producer honours o_full, consumer honours o_empty.
interface decoupler_if #(
    parameter int DATA_WIDTH = 32
);
    logic [2*DATA_WIDTH-1:0] i_data;
    logic                    i_enq;
    logic                    o_full;
    logic                    i_deq;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_empty;

    // The decoupler itself.
    modport slave (
        input  i_data, i_enq, i_deq,
        output o_full, o_data, o_empty
    );

    // Whoever feeds and drains the decoupler.
    modport master (
        output i_data, i_enq, i_deq,
        input  o_full, o_data, o_empty
    );
endinterface

// File: rtl/decoupler.sv
// Purpose: splits 2-record words into single records through a circular FIFO with a half-select.
// Latency: a word enqueued in cycle N is visible at o_data in N+1; one record per cycle sustained.
// Backpressure: enq dropped while o_full, deq dropped while o_empty; both flags come from registered state.
// Optional: define DECOUPLER_COUNT_EN to add o_count (records available = 2*entries - half).
module decoupler #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LOW_FIRST  = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
`ifdef DECOUPLER_COUNT_EN
    output logic [$clog2(DEPTH)+1:0] o_count,
`endif
    decoupler_if.slave               bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = 2 * DATA_WIDTH;

    logic [WW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_half;

    logic          w_full;
    logic          w_empty;
    logic          w_enq_ok;
    logic          w_deq_ok;
    logic          w_free;
    logic          w_sel_hi;
    logic [WW-1:0] w_head;

    // Flags depend only on the registered entry count, never on this cycle's requests.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_enq_ok = bus.i_enq & ~w_full & ~i_rst;
    assign w_deq_ok = bus.i_deq & ~w_empty & ~i_rst;
    // The entry is released only when its second record leaves.
    assign w_free   = w_deq_ok & r_half;

    assign bus.o_full  = w_full;
    assign bus.o_empty = w_empty;

    // Head record: the half being consumed is picked according to the emit order.
    assign w_head   = r_mem[r_rd_ptr];
    assign w_sel_hi = (LOW_FIRST != 0) ? r_half : ~r_half;
    assign bus.o_data = w_sel_hi ? w_head[WW-1:DATA_WIDTH] : w_head[DATA_WIDTH-1:0];

    // Storage write; contents are left as-is across reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_enq_ok) begin
            r_mem[r_wr_ptr] <= bus.i_data;
        end
    end

    // Pointers, half-select and entry count; pointer wrap is natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_half   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_enq_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq_ok) begin
                r_half <= ~r_half;
                if (r_half) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
            case ({w_enq_ok, w_free})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DECOUPLER_COUNT_EN
    localparam int RW = PW + 2;

    logic [RW-1:0] r_rec;
    logic [RW-1:0] w_rec_next;

    // Record count tracks the same accepted events: +2 per word in, -1 per record out.
    always_comb begin
        w_rec_next = r_rec;
        if (w_enq_ok) begin
            w_rec_next = w_rec_next + RW'(2);
        end
        if (w_deq_ok) begin
            w_rec_next = w_rec_next - RW'(1);
        end
    end

    // Registered record count, zero exactly when the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rec <= '0;
        end else begin
            r_rec <= w_rec_next;
        end
    end

    assign o_count = r_rec;
`endif
endmodule

// File: tb/tb_decoupler.sv
// Purpose: directed self-checking bench for decoupler (both emit orders).
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
// Backpressure: stimulus respects o_full / o_empty where a scenario calls for a well-behaved neighbour.
module tb_decoupler;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decoupler_if #(.DATA_WIDTH(32)) bus1 ();
    decoupler_if #(.DATA_WIDTH(32)) bus0 ();

`ifdef DECOUPLER_COUNT_EN
    logic [5:0] cnt1;
    logic [5:0] cnt0;
`endif

    decoupler #(.DATA_WIDTH(32), .DEPTH(16), .LOW_FIRST(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst   (rst),
`ifdef DECOUPLER_COUNT_EN
        .o_count (cnt1),
`endif
        .bus     (bus1)
    );

    decoupler #(.DATA_WIDTH(32), .DEPTH(16), .LOW_FIRST(0)) u_dut0 (
        .i_clk   (clk),
        .i_rst   (rst),
`ifdef DECOUPLER_COUNT_EN
        .o_count (cnt0),
`endif
        .bus     (bus0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Word k of a sequence holds records base+2k-1 (low) and base+2k (high).
    function automatic logic [63:0] mk_word(input int base, input int k);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = 32'(base + 2*k - 1);
        hi = 32'(base + 2*k);
        return {hi, lo};
    endfunction

    task automatic idle();
        bus1.i_enq = 1'b0; bus1.i_deq = 1'b0; bus1.i_data = '0;
        bus0.i_enq = 1'b0; bus0.i_deq = 1'b0; bus0.i_data = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus1.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty1: got %0b want 1", bus1.o_empty); end
        n_tests++; if (bus1.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full1: got %0b want 0", bus1.o_full); end
        n_tests++; if (bus0.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty0: got %0b want 1", bus0.o_empty); end
        n_tests++; if (bus0.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full0: got %0b want 0", bus0.o_full); end
`ifdef DECOUPLER_COUNT_EN
        n_tests++; if (cnt1 !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt1); end
`endif
    endtask

    task automatic test_low_first();
        @(negedge clk);
        bus1.i_enq = 1'b1; bus1.i_data = 64'h0000000200000001;
        @(negedge clk);
        bus1.i_enq = 1'b0;
        n_tests++; if (bus1.o_empty !== 1'b0) begin n_fail++; $display("FAIL lf1_empty_after_enq: got %0b want 0", bus1.o_empty); end
        n_tests++; if (bus1.o_data !== 32'h00000001) begin n_fail++; $display("FAIL lf1_rec0: got %h want 00000001", bus1.o_data); end
`ifdef DECOUPLER_COUNT_EN
        n_tests++; if (cnt1 !== 6'd2) begin n_fail++; $display("FAIL lf1_count2: got %0d want 2", cnt1); end
`endif
        bus1.i_deq = 1'b1;
        @(negedge clk);
        n_tests++; if (bus1.o_empty !== 1'b0) begin n_fail++; $display("FAIL lf1_empty_mid: got %0b want 0", bus1.o_empty); end
        n_tests++; if (bus1.o_data !== 32'h00000002) begin n_fail++; $display("FAIL lf1_rec1: got %h want 00000002", bus1.o_data); end
`ifdef DECOUPLER_COUNT_EN
        n_tests++; if (cnt1 !== 6'd1) begin n_fail++; $display("FAIL lf1_count1: got %0d want 1", cnt1); end
`endif
        @(negedge clk);
        bus1.i_deq = 1'b0;
        n_tests++; if (bus1.o_empty !== 1'b1) begin n_fail++; $display("FAIL lf1_empty_end: got %0b want 1", bus1.o_empty); end
`ifdef DECOUPLER_COUNT_EN
        n_tests++; if (cnt1 !== 6'd0) begin n_fail++; $display("FAIL lf1_count0: got %0d want 0", cnt1); end
`endif
    endtask

    task automatic test_high_first();
        @(negedge clk);
        bus0.i_enq = 1'b1; bus0.i_data = 64'h0000000200000001;
        @(negedge clk);
        bus0.i_enq = 1'b0;
        n_tests++; if (bus0.o_data !== 32'h00000002) begin n_fail++; $display("FAIL lf0_rec0: got %h want 00000002", bus0.o_data); end
        bus0.i_deq = 1'b1;
        @(negedge clk);
        n_tests++; if (bus0.o_data !== 32'h00000001) begin n_fail++; $display("FAIL lf0_rec1: got %h want 00000001", bus0.o_data); end
        @(negedge clk);
        bus0.i_deq = 1'b0;
        n_tests++; if (bus0.o_empty !== 1'b1) begin n_fail++; $display("FAIL lf0_empty_end: got %0b want 1", bus0.o_empty); end
    endtask

    task automatic test_fill_drop();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) begin
                n_tests++; if (bus1.o_full !== 1'b0) begin n_fail++; $display("FAIL fill_full_early: got %0b want 0", bus1.o_full); end
            end
            if (k == 17) begin
                n_tests++; if (bus1.o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full_at16: got %0b want 1", bus1.o_full); end
            end
            bus1.i_enq = 1'b1; bus1.i_data = mk_word(0, k);
        end
        @(negedge clk);
        bus1.i_enq = 1'b0;
        n_tests++; if (bus1.o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full_after17: got %0b want 1", bus1.o_full); end
        for (int r = 1; r <= 32; r++) begin
            n_tests++; if (bus1.o_data !== 32'(r) || bus1.o_empty !== 1'b0) begin n_fail++; $display("FAIL fill_drain_rec%0d: got %h empty %0b want %h empty 0", r, bus1.o_data, bus1.o_empty, 32'(r)); end
            bus1.i_deq = 1'b1;
            @(negedge clk);
        end
        bus1.i_deq = 1'b0;
        n_tests++; if (bus1.o_empty !== 1'b1) begin n_fail++; $display("FAIL fill_word17_dropped: empty got %0b want 1", bus1.o_empty); end
        n_tests++; if (bus1.o_full !== 1'b0) begin n_fail++; $display("FAIL fill_full_after_drain: got %0b want 0", bus1.o_full); end
    endtask

    task automatic test_full_wrap();
        int nxt;
        int rec;
        int acc;
        bit done;
        nxt = 17; rec = 1; acc = 0; done = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus1.i_enq = 1'b1; bus1.i_data = mk_word(100, k);
        end
        // Enq held high while draining one record per cycle.
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c < 4) begin
                n_tests++; if (bus1.o_full !== ((c == 2) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL wrap_full_c%0d: got %0b want %0b", c, bus1.o_full, (c == 2) ? 1'b0 : 1'b1); end
            end
            n_tests++; if (bus1.o_empty !== 1'b0 || bus1.o_data !== 32'(100 + rec)) begin n_fail++; $display("FAIL wrap_hold_rec%0d: got %h empty %0b want %h", rec, bus1.o_data, bus1.o_empty, 32'(100 + rec)); end
            rec++;
            bus1.i_deq  = 1'b1;
            bus1.i_enq  = 1'b1;
            bus1.i_data = mk_word(100, nxt);
            if (!bus1.o_full) begin
                nxt++;
                acc++;
            end
        end
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            bus1.i_enq = 1'b0;
            if (bus1.o_empty) begin
                done = 1'b1;
                bus1.i_deq = 1'b0;
            end else begin
                n_tests++; if (bus1.o_data !== 32'(100 + rec)) begin n_fail++; $display("FAIL wrap_drain_rec%0d: got %h want %h", rec, bus1.o_data, 32'(100 + rec)); end
                rec++;
                bus1.i_deq = 1'b1;
            end
        end
        bus1.i_deq = 1'b0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout: drained got %0b want 1", done); end
        n_tests++; if (acc !== 11) begin n_fail++; $display("FAIL wrap_accepted: got %0d want 11", acc); end
        n_tests++; if (rec - 1 !== 54) begin n_fail++; $display("FAIL wrap_total_records: got %0d want 54", rec - 1); end
    endtask

    task automatic test_stream();
        int sent;
        int got;
        int first;
        int last;
        bit saw_full;
        sent = 0; got = 0; first = -1; last = -1; saw_full = 1'b0;
        for (int c = 0; c < 400 && got < 128; c++) begin
            @(negedge clk);
            if (bus1.o_full) saw_full = 1'b1;
            bus1.i_deq = ~bus1.o_empty;
            if (!bus1.o_empty) begin
                n_tests++; if (bus1.o_data !== 32'(1000 + got + 1)) begin n_fail++; $display("FAIL stream_rec%0d: got %h want %h", got + 1, bus1.o_data, 32'(1000 + got + 1)); end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            bus1.i_enq = (sent < 64) && (c % 2 == 0) && !bus1.o_full;
            if (bus1.i_enq) begin
                bus1.i_data = mk_word(1000, sent + 1);
                sent++;
            end
        end
        @(negedge clk);
        idle();
        n_tests++; if (got !== 128) begin n_fail++; $display("FAIL stream_count: got %0d want 128", got); end
        n_tests++; if (saw_full !== 1'b0) begin n_fail++; $display("FAIL stream_full_seen: got %0b want 0", saw_full); end
        n_tests++; if (last - first + 1 !== 128) begin n_fail++; $display("FAIL stream_gapless: span got %0d want 128", last - first + 1); end
        n_tests++; if (bus1.o_empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty_end: got %0b want 1", bus1.o_empty); end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus1.i_enq = 1'b1; bus1.i_data = mk_word(200, k);
        end
        @(negedge clk);
        bus1.i_enq = 1'b0; bus1.i_deq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (bus1.o_data !== 32'd204) begin n_fail++; $display("FAIL rmid_head_before: got %0d want 204", bus1.o_data); end
        // Requests during the reset cycle must have no effect.
        rst = 1'b1;
        bus1.i_enq = 1'b1; bus1.i_deq = 1'b1; bus1.i_data = 64'hDEADBEEFCAFEF00D;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus1.o_empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty: got %0b want 1", bus1.o_empty); end
        n_tests++; if (bus1.o_full !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got %0b want 0", bus1.o_full); end
        // Enq and deq together while empty: deq ignored, word kept.
        bus1.i_enq = 1'b1; bus1.i_deq = 1'b1; bus1.i_data = 64'h0000000B0000000A;
        @(negedge clk);
        bus1.i_enq = 1'b0; bus1.i_deq = 1'b0;
        n_tests++; if (bus1.o_empty !== 1'b0 || bus1.o_data !== 32'h0000000A) begin n_fail++; $display("FAIL rmid_first: got %h empty %0b want 0000000a", bus1.o_data, bus1.o_empty); end
        bus1.i_deq = 1'b1;
        @(negedge clk);
        n_tests++; if (bus1.o_data !== 32'h0000000B) begin n_fail++; $display("FAIL rmid_second: got %h want 0000000b", bus1.o_data); end
        @(negedge clk);
        bus1.i_deq = 1'b0;
        n_tests++; if (bus1.o_empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty_end: got %0b want 1", bus1.o_empty); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_low_first();
        test_high_first();
        test_fill_drop();
        test_full_wrap();
        test_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
